// File: rtl/csrs_access.sv
// Initiator side of the CSR access bus: one Zicsr instruction at a time.
// It reads the CSR, computes the read-modify-write value, writes it back and returns the old value.
module csrs_access #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic [2:0]  REQ_OP,
    input  logic [11:0] REQ_ADDR,
    input  logic [31:0] REQ_RS1,
    input  logic [4:0]  REQ_UIMM,
    input  logic        REQ_RS1_ZERO,
    input  logic        REQ_RD_ZERO,
    input  logic        FLUSH,
    output logic        RDEN,
    output logic [11:0] RADDR,
    input  logic        RVALID,
    input  logic [31:0] RDATA,
    output logic        WREN,
    output logic [11:0] WADDR,
    output logic [31:0] WDATA,
    output logic        RESP_VALID,
    output logic [31:0] RESP_DATA,
    output logic        RESP_ERR
);

    localparam int unsigned AW = 12;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 8;

    localparam logic [1:0] K_ILL = 2'b00;
    localparam logic [1:0] K_RW  = 2'b01;
    localparam logic [1:0] K_RS  = 2'b10;
    localparam logic [1:0] K_RC  = 2'b11;

    // The timeout fires on the WT cycle whose miss would bring the count to TIMEOUT.
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WT,
        WR,
        RESP
    } state_t;

    state_t        state;
    logic [1:0]    kind_q;
    logic [DW-1:0] src_q;
    logic [DW-1:0] old_q;
    logic          rn_q;
    logic          wn_q;
    logic [CW-1:0] cnt;

    logic [1:0]    req_kind;
    logic [DW-1:0] req_src;
    logic          req_rn;
    logic          req_wn;
    logic          req_err;
    logic          accept;

    // Decode of the incoming request: operand source, read/write needs and legality.
    always_comb begin
        req_kind = REQ_OP[1:0];
        req_src  = REQ_OP[2] ? DW'(REQ_UIMM) : REQ_RS1;
        req_rn   = (req_kind != K_ILL) && ((req_kind != K_RW) || !REQ_RD_ZERO);
        req_wn   = (req_kind == K_RW)
                || ((req_kind != K_ILL)
                    && (REQ_OP[2] ? (REQ_UIMM != 5'd0) : !REQ_RS1_ZERO));
        req_err  = (req_kind == K_ILL) || (req_wn && (REQ_ADDR[11:10] == 2'b11));
    end

    assign REQ_READY = (state == IDLE) && RST && !FLUSH;
    assign accept    = REQ_VALID && REQ_READY;

    function automatic logic [DW-1:0] merge(input logic [1:0]    kind,
                                            input logic [DW-1:0] old,
                                            input logic [DW-1:0] src);
        logic [DW-1:0] res;
        case (kind)
            K_RS:    res = old | src;
            K_RC:    res = old & ~src;
            default: res = src;
        endcase
        return res;
    endfunction

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state      <= IDLE;
            kind_q     <= K_ILL;
            src_q      <= '0;
            old_q      <= '0;
            rn_q       <= 1'b0;
            wn_q       <= 1'b0;
            cnt        <= '0;
            RDEN       <= 1'b0;
            RADDR      <= '0;
            WREN       <= 1'b0;
            WADDR      <= '0;
            WDATA      <= '0;
            RESP_VALID <= 1'b0;
            RESP_DATA  <= '0;
            RESP_ERR   <= 1'b0;
        end else begin
            RDEN       <= 1'b0;
            WREN       <= 1'b0;
            RESP_VALID <= 1'b0;
            RESP_ERR   <= 1'b0;
            RESP_DATA  <= '0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        kind_q <= req_kind;
                        src_q  <= req_src;
                        rn_q   <= req_rn;
                        wn_q   <= req_wn;
                        RADDR  <= AW'(REQ_ADDR);
                        WADDR  <= AW'(REQ_ADDR);
                        if (req_err) begin
                            state      <= RESP;
                            RESP_VALID <= 1'b1;
                            RESP_ERR   <= 1'b1;
                        end else if (req_rn) begin
                            state <= RD;
                            RDEN  <= 1'b1;
                        end else begin
                            state <= WR;
                            WREN  <= 1'b1;
                            WDATA <= merge(req_kind, '0, req_src);
                        end
                    end
                end
                RD: begin
                    if (FLUSH) begin
                        state <= IDLE;
                        RADDR <= '0;
                        WADDR <= '0;
                    end else begin
                        state <= WT;
                        cnt   <= '0;
                    end
                end
                WT: begin
                    // Flush wins over a same-cycle RVALID.
                    if (FLUSH) begin
                        state <= IDLE;
                        RADDR <= '0;
                        WADDR <= '0;
                    end else if (RVALID) begin
                        old_q <= RDATA;
                        if (wn_q) begin
                            state <= WR;
                            WREN  <= 1'b1;
                            WDATA <= merge(kind_q, RDATA, src_q);
                        end else begin
                            state      <= RESP;
                            RESP_VALID <= 1'b1;
                            RESP_DATA  <= RDATA;
                        end
                    end else if (cnt == TO_LAST) begin
                        state      <= RESP;
                        RESP_VALID <= 1'b1;
                        RESP_ERR   <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                WR: begin
                    state      <= RESP;
                    RESP_VALID <= 1'b1;
                    RESP_DATA  <= rn_q ? old_q : '0;
                end
                RESP: begin
                    state <= IDLE;
                    RADDR <= '0;
                    WADDR <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
